// File: rtl/neural_layer_seq.sv
// neural_layer_seq: fully-connected layer that shares a single signed MAC across all neurons.
// Each neuron takes N_IN MAC cycles plus one activation cycle. Vectors enter and leave through valid/ready.
module neural_layer_seq #(
    parameter int INT_WIDTH  = 8,
    parameter int N_IN       = 4,
    parameter int N_OUT      = 2,
    parameter int W_WIDTH    = INT_WIDTH + 2,
    parameter int ACT_MODE   = 0,
    parameter int ADDR_WIDTH = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_we,
    input  logic [ADDR_WIDTH-1:0]        w_addr,
    input  logic [W_WIDTH-1:0]           w_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [N_IN*INT_WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_OUT*INT_WIDTH-1:0]   out_data
);

    localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int ACC_W = INT_WIDTH + W_WIDTH + $clog2(N_IN) + 1;

    localparam logic signed [ACC_W-1:0] INT_MAX_S = ACC_W'(2 ** INT_WIDTH - 1);
    localparam logic signed [ACC_W-1:0] HALF_S    = ACC_W'((2 ** INT_WIDTH - 1) / 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [IW-1:0]                i_q, i_d;
    logic [OW-1:0]                o_q, o_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [INT_WIDTH-1:0]         inLatch_q [N_IN];
    logic signed [W_WIDTH-1:0]    weight_q  [N_OUT][N_IN];
    logic [INT_WIDTH-1:0]         result_q  [N_OUT];

    logic signed [W_WIDTH-1:0]    wSel;
    logic signed [INT_WIDTH:0]    inExt;
    logic signed [ACC_W-1:0]      product;
    logic signed [ACC_W-1:0]      scaled;
    logic [INT_WIDTH-1:0]         actVal;
    logic                         accept;

    assign accept    = (state_q == S_IDLE) && in_valid;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);

    // Inputs are zero-extended so the unsigned activation multiplies correctly against a signed weight.
    always_comb begin
        wSel    = weight_q[o_q][i_q];
        inExt   = $signed({1'b0, inLatch_q[i_q]});
        product = ACC_W'(inExt) * ACC_W'(wSel);
        scaled  = acc_q >>> INT_WIDTH;
        actVal  = '0;
        if (ACT_MODE == 0) begin
            if (scaled < 0) begin
                actVal = '0;
            end else if (scaled > INT_MAX_S) begin
                actVal = INT_MAX_S[INT_WIDTH-1:0];
            end else begin
                actVal = scaled[INT_WIDTH-1:0];
            end
        end else begin
            actVal = (scaled > HALF_S) ? INT_MAX_S[INT_WIDTH-1:0] : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        o_d     = o_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_MAC;
                    i_d     = '0;
                    o_d     = '0;
                    acc_d   = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + product;
                if (i_q == IW'(N_IN - 1)) begin
                    state_d = S_ACT;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_ACT: begin
                acc_d = '0;
                i_d   = '0;
                if (o_q == OW'(N_OUT - 1)) begin
                    state_d = S_OUT;
                end else begin
                    o_d     = o_q + 1'b1;
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            o_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            acc_q   <= acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_IN; i++) begin
                inLatch_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_IN; i++) begin
                inLatch_q[i] <= in_data[i*INT_WIDTH +: INT_WIDTH];
            end
        end
    end

    // Writes land only in IDLE, so weights cannot shift under an in-flight vector; unmatched addresses fall through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < N_OUT; o++) begin
                for (int i = 0; i < N_IN; i++) begin
                    weight_q[o][i] <= '0;
                end
            end
        end else if ((state_q == S_IDLE) && w_we) begin
            for (int o = 0; o < N_OUT; o++) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (w_addr == ADDR_WIDTH'(o * N_IN + i)) begin
                        weight_q[o][i] <= w_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < N_OUT; o++) begin
                result_q[o] <= '0;
            end
        end else if (state_q == S_ACT) begin
            result_q[o_q] <= actVal;
        end
    end

    always_comb begin
        out_data = '0;
        for (int o = 0; o < N_OUT; o++) begin
            out_data[o*INT_WIDTH +: INT_WIDTH] = result_q[o];
        end
    end

endmodule

// File: tb/tb_neural_layer_seq.sv
// tb_neural_layer_seq: directed checks of a 2x2 clamp layer and a two-layer threshold XOR chain.
// Expected values are hand-computed from the layer arithmetic (acc >>> 8, then clamp or threshold).
module tb_neural_layer_seq;

    logic clk = 1'b0;
    logic rst;

    logic        aWWe;
    logic [1:0]  aWAddr;
    logic [9:0]  aWData;
    logic        aInValid;
    logic        aInReady;
    logic [15:0] aInData;
    logic        aOutValid;
    logic        aOutReady;
    logic [15:0] aOutData;

    logic        x1WWe;
    logic [1:0]  x1WAddr;
    logic [9:0]  x1WData;
    logic        x1InValid;
    logic        x1InReady;
    logic [15:0] x1InData;
    logic        x1OutValid;
    logic        x1OutReady;
    logic [15:0] x1OutData;

    logic        x2WWe;
    logic [0:0]  x2WAddr;
    logic [9:0]  x2WData;
    logic        x2OutValid;
    logic        x2OutReady;
    logic [7:0]  x2OutData;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    neural_layer_seq #(.INT_WIDTH(8), .N_IN(2), .N_OUT(2), .ACT_MODE(0)) dutA (
        .clk(clk), .rst(rst),
        .w_we(aWWe), .w_addr(aWAddr), .w_data(aWData),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData)
    );

    neural_layer_seq #(.INT_WIDTH(8), .N_IN(2), .N_OUT(2), .ACT_MODE(1)) dutX1 (
        .clk(clk), .rst(rst),
        .w_we(x1WWe), .w_addr(x1WAddr), .w_data(x1WData),
        .in_valid(x1InValid), .in_ready(x1InReady), .in_data(x1InData),
        .out_valid(x1OutValid), .out_ready(x1OutReady), .out_data(x1OutData)
    );

    neural_layer_seq #(.INT_WIDTH(8), .N_IN(2), .N_OUT(1), .ACT_MODE(1)) dutX2 (
        .clk(clk), .rst(rst),
        .w_we(x2WWe), .w_addr(x2WAddr), .w_data(x2WData),
        .in_valid(x1OutValid), .in_ready(x1OutReady), .in_data(x1OutData),
        .out_valid(x2OutValid), .out_ready(x2OutReady), .out_data(x2OutData)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // which: 0 = clamp layer, 1 = XOR first layer, 2 = XOR second layer
    task automatic writeWeight(input int which, input int addr, input int data);
        @(negedge clk);
        case (which)
            0: begin aWWe = 1'b1; aWAddr = 2'(addr); aWData = 10'(data); end
            1: begin x1WWe = 1'b1; x1WAddr = 2'(addr); x1WData = 10'(data); end
            default: begin x2WWe = 1'b1; x2WAddr = 1'(addr); x2WData = 10'(data); end
        endcase
        @(posedge clk);
        #1;
        aWWe = 1'b0;
        x1WWe = 1'b0;
        x2WWe = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] vec, output int latency);
        @(negedge clk);
        aInData  = vec;
        aInValid = 1'b1;
        @(posedge clk);
        #1;
        aInValid = 1'b0;
        latency = 0;
        while (!aOutValid && latency < 50) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic consumeA();
        @(negedge clk);
        aOutReady = 1'b1;
        @(posedge clk);
        #1;
        aOutReady = 1'b0;
        checkOutput("a_valid_drop", 32'(aOutValid), 32'd0);
        checkOutput("a_ready_back", 32'(aInReady), 32'd1);
    endtask

    task automatic runXor(input int pattern, input logic [7:0] expOut);
        @(negedge clk);
        x1InData  = {(pattern[1] ? 8'd255 : 8'd0), (pattern[0] ? 8'd255 : 8'd0)};
        x1InValid = 1'b1;
        @(posedge clk);
        #1;
        x1InValid = 1'b0;
        lat = 0;
        while (!x2OutValid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput($sformatf("xor_lat_%0d", pattern), 32'(lat), 32'd10);
        checkOutput($sformatf("xor_out_%0d", pattern), 32'(x2OutData), 32'(expOut));
        @(negedge clk);
        x2OutReady = 1'b1;
        @(posedge clk);
        #1;
        x2OutReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        aWWe = 1'b0; aWAddr = '0; aWData = '0; aInValid = 1'b0; aInData = '0; aOutReady = 1'b0;
        x1WWe = 1'b0; x1WAddr = '0; x1WData = '0; x1InValid = 1'b0; x1InData = '0;
        x2WWe = 1'b0; x2WAddr = '0; x2WData = '0; x2OutReady = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 32'(aInReady), 32'd1);
        checkOutput("rst_out_valid", 32'(aOutValid), 32'd0);
        checkOutput("rst_out_data", 32'(aOutData), 32'd0);
        rst = 1'b1;

        applyStimulus({8'h34, 8'h12}, lat);
        checkOutput("zero_w_lat", 32'(lat), 32'd6);
        checkOutput("zero_w_data", 32'(aOutData), 32'h0000);
        consumeA();

        writeWeight(0, 0, 256);
        writeWeight(0, 1, 256);
        writeWeight(0, 2, -256);
        writeWeight(0, 3, 256);
        applyStimulus({8'd0, 8'd255}, lat);
        checkOutput("clamp_neg_lat", 32'(lat), 32'd6);
        checkOutput("clamp_neg_data", 32'(aOutData), 32'h00FF);
        consumeA();

        // acc = 130560 -> scaled 510 saturates; neuron 1 cancels to zero
        applyStimulus({8'd255, 8'd255}, lat);
        checkOutput("sat_data", 32'(aOutData), 32'h00FF);
        consumeA();

        writeWeight(0, 0, 128);
        writeWeight(0, 1, 128);
        writeWeight(0, 2, 128);
        writeWeight(0, 3, 128);
        applyStimulus({8'd255, 8'd255}, lat);
        checkOutput("frac_data", 32'(aOutData), 32'hFFFF);
        consumeA();

        // neuron0: 200*100+10*50=20500 -> 80; neuron1: -2000+3000=1000 -> 3
        writeWeight(0, 0, 100);
        writeWeight(0, 1, 50);
        writeWeight(0, 2, -10);
        writeWeight(0, 3, 300);
        applyStimulus({8'd10, 8'd200}, lat);
        checkOutput("mixed_lat", 32'(lat), 32'd6);
        checkOutput("mixed_data", 32'(aOutData), 32'h0350);

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            aWWe   = (c == 3);
            aWAddr = 2'd0;
            aWData = 10'd0;
            @(posedge clk);
            #1;
            checkOutput($sformatf("stall_valid_%0d", c), 32'(aOutValid), 32'd1);
            checkOutput($sformatf("stall_data_%0d", c), 32'(aOutData), 32'h0350);
            checkOutput($sformatf("stall_ready_%0d", c), 32'(aInReady), 32'd0);
        end
        aWWe = 1'b0;
        consumeA();
        applyStimulus({8'd10, 8'd200}, lat);
        checkOutput("stall_write_ignored", 32'(aOutData), 32'h0350);
        consumeA();

        @(negedge clk);
        aInData  = {8'd10, 8'd200};
        aInValid = 1'b1;
        @(posedge clk);
        #1;
        aInValid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", 32'(aInReady), 32'd1);
        checkOutput("abort_out_valid", 32'(aOutValid), 32'd0);
        checkOutput("abort_out_data", 32'(aOutData), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus({8'd10, 8'd200}, lat);
        checkOutput("abort_lat", 32'(lat), 32'd6);
        checkOutput("abort_cleared_w", 32'(aOutData), 32'h0000);
        consumeA();

        writeWeight(1, 0, 127);
        writeWeight(1, 1, 128);
        writeWeight(1, 2, 256);
        writeWeight(1, 3, 256);
        writeWeight(2, 0, -256);
        writeWeight(2, 1, 256);
        runXor(0, 8'd0);
        runXor(1, 8'd255);
        runXor(2, 8'd255);
        runXor(3, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
